// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter
// Shares the single register-file write port between the two issue lanes.
// Each cycle the oldest pending result (queue head, then lane 1, then lane 2)
// is registered onto the write port; the remaining results wait in a small
// in-order circular queue. The scheduler gets a stall when the queue is
// close to full and hazard hits for registers that still have a pending write.
//
// Ports:
//   clk, n_rst                      clock (rising edge), async active-low reset
//   laneN_wr_en/laneN_rd/laneN_data lane N result (lane 1 older than lane 2)
//   rf_we/rf_waddr/rf_wdata         registered register-file write port
//   stall                           upstream must hold off (count >= DEPTH-1)
//   pending_count                   queue occupancy, excluding the output register
//   query1/query2                   source registers checked for pending writes
//   hazard_hit1/hazard_hit2         a pending write to query1/query2 exists
//   overflow_err                    sticky, a write was dropped
module writeback_port_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       lane1_wr_en,
  input  logic [4:0]                 lane1_rd,
  input  logic [DATA_W-1:0]          lane1_data,
  input  logic                       lane2_wr_en,
  input  logic [4:0]                 lane2_rd,
  input  logic [DATA_W-1:0]          lane2_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     pending_count,
  input  logic [4:0]                 query1,
  input  logic [4:0]                 query2,
  output logic                       hazard_hit1,
  output logic                       hazard_hit2,
  output logic                       overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RD_W  = 5;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [RD_W-1:0]   mem_rd_q   [DEPTH];
  logic [RD_W-1:0]   mem_rd_d   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic              rf_we_q, rf_we_d;
  logic [RD_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              overflow_q, overflow_d;

  logic              l1_v, l2_v, q_nonempty;
  logic              e0_v, e1_v, acc0, acc1;
  logic [RD_W-1:0]   e0_rd, e1_rd;
  logic [DATA_W-1:0] e0_data, e1_data;
  logic [CNT_W-1:0]  space;
  logic [PTR_W-1:0]  tail_nx;
  logic [DEPTH-1:0]  entry_valid;

  // Arbitration, enqueue and occupancy update for one cycle.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    overflow_d = overflow_q;
    e0_v       = 1'b0;
    e1_v       = 1'b0;
    e0_rd      = lane2_rd;
    e0_data    = lane2_data;
    e1_rd      = lane2_rd;
    e1_data    = lane2_data;

    // x0 writes vanish; on equal rd the younger lane 2 result wins.
    l1_v = lane1_wr_en && (lane1_rd != '0);
    l2_v = lane2_wr_en && (lane2_rd != '0);
    if (l1_v && l2_v && (lane1_rd == lane2_rd)) begin
      l1_v = 1'b0;
    end
    q_nonempty = (count_q != '0);

    // Stream head: queue, then lane 1, then lane 2.
    if (q_nonempty) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_rd_q[head_q];
      rf_wdata_d = mem_data_q[head_q];
    end else if (l1_v) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lane1_rd;
      rf_wdata_d = lane1_data;
    end else if (l2_v) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lane2_rd;
      rf_wdata_d = lane2_data;
    end

    // Incoming writes that did not take the port, oldest first.
    if (q_nonempty) begin
      if (l1_v) begin
        e0_v    = 1'b1;
        e0_rd   = lane1_rd;
        e0_data = lane1_data;
        e1_v    = l2_v;
      end else begin
        e0_v = l2_v;
      end
    end else begin
      e0_v = l1_v && l2_v;
    end

    // Retiring from the queue frees its slot before enqueue.
    space = CNT_W'(DEPTH) - count_q + CNT_W'(q_nonempty);
    acc0  = e0_v && (space >= CNT_W'(1));
    acc1  = e1_v && (space >= CNT_W'(2));
    if ((e0_v && !acc0) || (e1_v && !acc1)) begin
      overflow_d = 1'b1;
    end

    tail_nx = tail_q + PTR_W'(1);
    if (acc0) begin
      mem_rd_d[tail_q]   = e0_rd;
      mem_data_d[tail_q] = e0_data;
    end
    if (acc1) begin
      mem_rd_d[tail_nx]   = e1_rd;
      mem_data_d[tail_nx] = e1_data;
    end
    tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
    head_d  = head_q + PTR_W'(q_nonempty);
    count_d = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(q_nonempty);
  end

  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q);
    end
  end

  // Pending-write hazards: live queue entries plus the output register.
  always_comb begin
    hazard_hit1 = rf_we_q && (rf_waddr_q == query1);
    hazard_hit2 = rf_we_q && (rf_waddr_q == query2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (mem_rd_q[i] == query1)) hazard_hit1 = 1'b1;
      if (entry_valid[i] && (mem_rd_q[i] == query2)) hazard_hit2 = 1'b1;
    end
    if (query1 == '0) hazard_hit1 = 1'b0;
    if (query2 == '0) hazard_hit2 = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      overflow_q <= overflow_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign pending_count = count_q;
  assign overflow_err  = overflow_q;
  // Leaves room for one more cycle of dual writes.
  assign stall         = (count_q >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_writeback_port_arbiter.sv
module tb_writeback_port_arbiter;

  logic        clk;
  logic        n_rst;
  logic        lane1_wr_en, lane2_wr_en;
  logic [4:0]  lane1_rd, lane2_rd;
  logic [31:0] lane1_data, lane2_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic [2:0]  pending_count;
  logic [4:0]  query1, query2;
  logic        hazard_hit1, hazard_hit2;
  logic        overflow_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  writeback_port_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .lane1_wr_en(lane1_wr_en), .lane1_rd(lane1_rd), .lane1_data(lane1_data),
    .lane2_wr_en(lane2_wr_en), .lane2_rd(lane2_rd), .lane2_data(lane2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall(stall), .pending_count(pending_count),
    .query1(query1), .query2(query2),
    .hazard_hit1(hazard_hit1), .hazard_hit2(hazard_hit2),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Present one cycle of lane inputs; returns just after the capturing edge.
  task automatic step(input logic e1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic e2, input logic [4:0] r2, input logic [31:0] d2);
    lane1_wr_en = e1; lane1_rd = r1; lane1_data = d1;
    lane2_wr_en = e2; lane2_rd = r2; lane2_data = d2;
    @(posedge clk);
    #1;
    lane1_wr_en = 1'b0;
    lane2_wr_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Write-port monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (n_rst && rf_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got write x%0d=%0h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(rf_waddr), 64'(e.rd));
        chk("wb_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  int drained;

  initial begin
    n_rst = 1'b0;
    lane1_wr_en = 1'b0; lane1_rd = '0; lane1_data = '0;
    lane2_wr_en = 1'b0; lane2_rd = '0; lane2_data = '0;
    query1 = 5'd5; query2 = 5'd6;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_count", 64'(pending_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_hit1", 64'(hazard_hit1), 64'd0);
    n_rst = 1'b1;
    idle();

    // Single write
    exp_push(5'd5, 32'hAAAA5555);
    step(1'b1, 5'd5, 32'hAAAA5555, 1'b0, 5'd0, 32'd0);
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_count", 64'(pending_count), 64'd0);
    chk("single_hit_outreg", 64'(hazard_hit1), 64'd1);
    idle();
    chk("idle_we", 64'(rf_we), 64'd0);
    chk("idle_waddr_hold", 64'(rf_waddr), 64'd5);
    chk("idle_wdata_hold", 64'(rf_wdata), 64'hAAAA5555);
    chk("idle_hit_clear", 64'(hazard_hit1), 64'd0);

    // Dual write, different rd
    exp_push(5'd3, 32'h11);
    exp_push(5'd4, 32'h22);
    query1 = 5'd3; query2 = 5'd4;
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    chk("dual_count1", 64'(pending_count), 64'd1);
    chk("dual_hit2_queue", 64'(hazard_hit2), 64'd1);
    chk("dual_hit1_outreg", 64'(hazard_hit1), 64'd1);
    idle();
    chk("dual_count0", 64'(pending_count), 64'd0);
    chk("dual_waddr2", 64'(rf_waddr), 64'd4);
    idle();
    chk("dual_done_we", 64'(rf_we), 64'd0);

    // Same-rd coalescing and x0 drop
    exp_push(5'd7, 32'h2);
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    chk("coal_count", 64'(pending_count), 64'd0);
    idle();
    chk("coal_once", 64'(rf_we), 64'd0);
    step(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_count", 64'(pending_count), 64'd0);
    idle();

    // Back-pressure and overflow: x10..x18 survive, x19 is the dropped one
    for (int i = 0; i < 9; i++) exp_push(5'(10 + i), 32'(32'h100 + i));
    step(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101);
    chk("bp_count1", 64'(pending_count), 64'd1);
    chk("bp_stall1", 64'(stall), 64'd0);
    step(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103);
    chk("bp_count2", 64'(pending_count), 64'd2);
    chk("bp_stall2", 64'(stall), 64'd0);
    step(1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105);
    chk("bp_count3", 64'(pending_count), 64'd3);
    chk("bp_stall3", 64'(stall), 64'd1);
    step(1'b1, 5'd16, 32'h106, 1'b1, 5'd17, 32'h107);
    chk("bp_count4", 64'(pending_count), 64'd4);
    chk("bp_noovf_fit", 64'(overflow_err), 64'd0);
    step(1'b1, 5'd18, 32'h108, 1'b1, 5'd19, 32'h109);
    chk("bp_count_sat", 64'(pending_count), 64'd4);
    chk("bp_ovf", 64'(overflow_err), 64'd1);
    drained = rf_we ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (rf_we) drained++;
    end
    chk("bp_drain_cnt", 64'(drained), 64'd5);
    chk("bp_count_empty", 64'(pending_count), 64'd0);
    chk("bp_ovf_sticky", 64'(overflow_err), 64'd1);

    // Hazard query
    exp_push(5'd8, 32'h81);
    exp_push(5'd9, 32'h92);
    exp_push(5'd9, 32'h93);
    query1 = 5'd9; query2 = 5'd8;
    step(1'b1, 5'd8, 32'h81, 1'b1, 5'd9, 32'h92);
    chk("hz_q_hit1", 64'(hazard_hit1), 64'd1);
    chk("hz_out_hit2", 64'(hazard_hit2), 64'd1);
    query1 = 5'd0;
    #1;
    chk("hz_x0", 64'(hazard_hit1), 64'd0);
    query1 = 5'd9;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h93);
    chk("hz_b_hit1", 64'(hazard_hit1), 64'd1);
    chk("hz_b_count", 64'(pending_count), 64'd1);
    idle();
    chk("hz_c_hit1", 64'(hazard_hit1), 64'd1);
    chk("hz_c_count", 64'(pending_count), 64'd0);
    idle();
    chk("hz_d_hit1", 64'(hazard_hit1), 64'd0);

    // Reset mid-stream at count 3: only x20 and x21 reach the port
    exp_push(5'd20, 32'h200);
    exp_push(5'd21, 32'h201);
    query1 = 5'd23;
    step(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201);
    step(1'b1, 5'd22, 32'h202, 1'b1, 5'd23, 32'h203);
    step(1'b1, 5'd24, 32'h204, 1'b1, 5'd25, 32'h205);
    chk("mr_count3", 64'(pending_count), 64'd3);
    chk("mr_hit_pre", 64'(hazard_hit1), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("mr_we", 64'(rf_we), 64'd0);
    chk("mr_waddr", 64'(rf_waddr), 64'd0);
    chk("mr_wdata", 64'(rf_wdata), 64'd0);
    chk("mr_count", 64'(pending_count), 64'd0);
    chk("mr_stall", 64'(stall), 64'd0);
    chk("mr_ovf", 64'(overflow_err), 64'd0);
    chk("mr_hit", 64'(hazard_hit1), 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle();
    chk("post_rst_we", 64'(rf_we), 64'd0);
    chk("post_rst_count", 64'(pending_count), 64'd0);
    idle();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_port_arbiter.md
# writeback_port_arbiter

Shares the single register-file write port between the two issue lanes of the dual-issue scheduler. Each cycle either lane (or both) may retire a result. The arbiter writes one result per cycle in program order, where lane 1 is older than lane 2, and buffers the rest in a small in-order queue. It reports pending-write hazards back to the scheduler and back-pressures the lanes before the queue can overflow. It sits between the lane datapaths' writeback stage and the register file.

## Interface
- DEPTH, 4: pending-queue entries; power of two, ≥ 2.
- DATA_W, 32: result width.

- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- lane1_wr_en  in  1  lane 1 presents a result this cycle.
- lane1_rd  in  5  lane 1 destination register.
- lane1_data  in  DATA_W  lane 1 result.
- lane2_wr_en / lane2_rd / lane2_data  in  1/5/DATA_W  same fields for lane 2, which is the younger instruction.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  write address (registered).
- rf_wdata  out  DATA_W  write data (registered).
- stall  out  1  upstream must not present writes this cycle.
- pending_count  out  $clog2(DEPTH)+1  queue occupancy, excluding the output register.
- query1, query2  in  5  source registers to check for pending writes.
- hazard_hit1, hazard_hit2  out  1  pending write exists to query1 / query2.
- overflow_err  out  1  sticky; a write was lost.

## Operation
- **Input filtering:** a lane write whose rd is 0 is discarded.
- **Same-cycle coalescing:** if both lanes are valid with equal nonzero rd, the lane 1 write is discarded, because lane 2 is younger and wins.
- **Arbitration stream:** the ordered stream each cycle is queue entries (head first), then lane 1, then lane 2.
- **Retire:** if the stream is non-empty, its head is loaded into the output register (rf_we=1 next cycle). Otherwise rf_we=0 next cycle, and rf_waddr/rf_wdata hold their previous values.
- **Enqueue:** surviving incoming writes that did not retire are enqueued in order, lane 1 before lane 2.
- **Occupancy update:** next_count = count + n_in − (stream non-empty), where n_in ∈ {0,1,2} after filtering.
- **Overflow:** if next_count would exceed DEPTH, the youngest excess writes are dropped, count saturates at DEPTH, and overflow_err sets and holds until reset.
- **stall:** combinational from registered count: stall = (count ≥ DEPTH−1). This guarantees space for one cycle of two writes. Writes presented while stall=1 are still accepted if they fit.
- **Hazard detection:** hazard_hit_k = (query_k ≠ 0) and (any valid queue entry has rd == query_k, or rf_we=1 with rf_waddr == query_k). Incoming lane writes in the same cycle are not included. Purely combinational.
- **Storage:** circular buffer with head/tail pointers, which wrap modulo DEPTH, and a count register. Full is count==DEPTH and empty is count==0; no pointer-equality ambiguity.

## Timing
- **Reset values:** rf_we=0, rf_waddr=0, rf_wdata=0, pending_count=0, stall=0, overflow_err=0, hazard_hit1/2=0 (queue empty, so no hit). Pointers are 0.
- **Latency:** a lane write reaches the register-file port 1 cycle after presentation when the queue is empty. Each queued entry ahead of it adds 1 cycle.
- **Throughput:** one register-file write per cycle. Sustained dual writes grow the queue by 1 per cycle until stall asserts.
- **Reset mid-operation:** all queued writes are discarded immediately, outputs return to reset values asynchronously, and no partial write is issued.
- **Simultaneous enqueue and retire at full:** the retire frees a slot first, so count==DEPTH with one incoming write stays at DEPTH without overflow.

## Test plan
- **Reset:** assert n_rst=0 mid-stream with count=3 → all outputs 0 within the same cycle. After release, pending_count=0 and rf_we=0.
- **Single write:** lane1 x5=0xAAAA5555, queue empty → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAAAA5555, pending_count=0.
- **Dual write, different rd:** lane1 x3=0x11 and lane2 x4=0x22 in the same cycle → cycle+1 writes x3 with pending_count=1 and hazard_hit for query=4. Cycle+2 writes x4 with pending_count=0.
- **Same-rd coalescing and x0 drop:**
  - lane1 x7=0x1 and lane2 x7=0x2 → only x7=0x2 is written, once.
  - lane1 x0=0xFF alone → rf_we stays 0.
- **Back-pressure and overflow (DEPTH=4):**
  - Dual writes every cycle → pending_count goes 1,2,3, and stall=1 at count 3.
  - Forcing dual writes for 2 more cycles → overflow_err=1 and pending_count saturates at 4.
  - After inputs stop, exactly 5 further writes drain in program order.
- **Hazard query:** lane2 writes x9 while the queue holds x9 → hazard_hit1=1 for query1=9 until the second x9 write leaves the output register. query1=0 → hazard_hit1=0 always.
